// File: rtl/bsg_print_stat_pkg.sv
// Shared definitions for the print-stat tag tracker: record kinds, tag field
// layout and the record layout {kind, id, cycle, elapsed}.
package bsg_print_stat_pkg;

   typedef enum logic [1:0] {
      KIND_STAT  = 2'd0,
      KIND_START = 2'd1,
      KIND_END   = 2'd2,
      KIND_RSVD  = 2'd3
   } rec_kind_e;

   // Kind occupies the top TAG_KIND_W bits of the tag, the ID the bottom bits.
   localparam int TAG_KIND_W  = 2;
   localparam int TAG_ID_LSB  = 0;
   localparam int REC_ID_W    = 4;
   localparam int REC_CYCLE_W = 40;

   // Record layout at default widths; the tracker rebuilds it at its own widths.
   typedef struct packed {
      rec_kind_e              kind;
      logic [REC_ID_W-1:0]    id;
      logic [REC_CYCLE_W-1:0] cycle;
      logic [REC_CYCLE_W-1:0] elapsed;
   } rec_s;

   function automatic int tag_kind_lsb(input int data_width);
      return data_width - TAG_KIND_W;
   endfunction

endpackage

// File: rtl/bsg_print_stat_rec_fifo.sv
// Valid/ready record FIFO; fullness is judged from registered occupancy only,
// and a dequeue never applies while the FIFO is empty.
module bsg_print_stat_rec_fifo #(
   parameter int width_p = 8,
   parameter int els_p   = 4
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   input  logic               ready_i,
   output logic [width_p-1:0] data_o
);
   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = $clog2(els_p + 1);
   localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
   localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

   logic [width_p-1:0]  r_mem [els_p];
   logic [ptr_w_lp-1:0] r_wr_ptr;
   logic [ptr_w_lp-1:0] r_rd_ptr;
   logic [cnt_w_lp-1:0] r_count;
   logic                w_enq;
   logic                w_deq;

   function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] ptr);
      return (ptr == last_ptr_lp) ? '0 : ptr + ptr_w_lp'(1);
   endfunction

   assign ready_o = (r_count != full_cnt_lp);
   assign v_o     = (r_count != '0);
   assign w_enq   = v_i & ready_o;
   assign w_deq   = v_o & ready_i;
   // Masking with v_o keeps the record fields at zero while empty or in reset.
   assign data_o  = v_o ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge clk_i) begin
      if (w_enq) begin
         r_mem[r_wr_ptr] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_deq) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + cnt_w_lp'(1);
            2'b01:   r_count <= r_count - cnt_w_lp'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/bsg_print_stat_tag_tracker.sv
// Snoops print-stat tags, times start/end intervals per tag ID and queues
// {kind, id, cycle, elapsed} records for a valid/ready consumer.
module bsg_print_stat_tag_tracker
   import bsg_print_stat_pkg::*;
#(
   parameter int data_width_p  = 32,
   parameter int cycle_width_p = 40,
   parameter int fifo_els_p    = 4,
   parameter int tag_els_p     = 16
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic                         print_stat_v_i,
   input  logic [data_width_p-1:0]      print_stat_tag_i,
   output logic                         rec_v_o,
   input  logic                         rec_ready_i,
   output logic [1:0]                   rec_kind_o,
   output logic [$clog2(tag_els_p)-1:0] rec_id_o,
   output logic [cycle_width_p-1:0]     rec_cycle_o,
   output logic [cycle_width_p-1:0]     rec_elapsed_o,
   output logic [15:0]                  drop_count_o,
   output logic                         err_o
);
   localparam int id_w_lp     = $clog2(tag_els_p);
   localparam int kind_lsb_lp = tag_kind_lsb(data_width_p);

   typedef struct packed {
      rec_kind_e                kind;
      logic [id_w_lp-1:0]       id;
      logic [cycle_width_p-1:0] cycle;
      logic [cycle_width_p-1:0] elapsed;
   } rec_t;

   rec_kind_e                w_kind;
   logic [id_w_lp-1:0]       w_id;
   logic                     w_unused_tag;
   rec_t                     w_enq_rec;
   rec_t                     w_deq_rec;
   logic                     w_enq_v;
   logic                     w_fifo_ready;
   logic                     w_set_err;
   logic                     w_open;
   logic                     w_close;
   logic [cycle_width_p-1:0] r_cycle;
   logic [tag_els_p-1:0]     r_active;
   logic [cycle_width_p-1:0] r_start [tag_els_p];
   logic [15:0]              r_drop_count;
   logic                     r_err;

   assign w_kind       = rec_kind_e'(print_stat_tag_i[kind_lsb_lp +: TAG_KIND_W]);
   assign w_id         = print_stat_tag_i[TAG_ID_LSB +: id_w_lp];
   assign w_unused_tag = ^print_stat_tag_i;

   always_comb begin
      w_enq_v           = 1'b0;
      w_set_err         = 1'b0;
      w_open            = 1'b0;
      w_close           = 1'b0;
      w_enq_rec.kind    = w_kind;
      w_enq_rec.id      = w_id;
      w_enq_rec.cycle   = r_cycle;
      w_enq_rec.elapsed = '0;
      if (print_stat_v_i) begin
         case (w_kind)
            KIND_STAT: begin
               w_enq_v = 1'b1;
            end
            KIND_START: begin
               w_enq_v = 1'b1;
               w_open  = 1'b1;
            end
            KIND_END: begin
               w_enq_v = 1'b1;
               // Unsigned subtraction gives the elapsed time modulo the counter width.
               if (r_active[w_id]) begin
                  w_close           = 1'b1;
                  w_enq_rec.elapsed = r_cycle - r_start[w_id];
               end else begin
                  w_set_err = 1'b1;
               end
            end
            default: begin
               w_set_err = 1'b1;
            end
         endcase
      end else begin
         w_enq_v = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_cycle      <= '0;
         r_active     <= '0;
         r_err        <= 1'b0;
         r_drop_count <= 16'd0;
         for (int i = 0; i < tag_els_p; i++) begin
            r_start[i] <= '0;
         end
      end else begin
         r_cycle <= r_cycle + cycle_width_p'(1);
         if (w_open) begin
            r_active[w_id] <= 1'b1;
            r_start[w_id]  <= r_cycle;
         end else if (w_close) begin
            r_active[w_id] <= 1'b0;
         end
         if (w_set_err) begin
            r_err <= 1'b1;
         end
         if (w_enq_v && !w_fifo_ready && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
         end
      end
   end

   bsg_print_stat_rec_fifo #(
      .width_p ($bits(rec_t)),
      .els_p   (fifo_els_p)
   ) u_rec_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (w_enq_v),
      .ready_o   (w_fifo_ready),
      .data_i    (w_enq_rec),
      .v_o       (rec_v_o),
      .ready_i   (rec_ready_i),
      .data_o    (w_deq_rec)
   );

   assign rec_kind_o    = w_deq_rec.kind;
   assign rec_id_o      = w_deq_rec.id;
   assign rec_cycle_o   = w_deq_rec.cycle;
   assign rec_elapsed_o = w_deq_rec.elapsed;
   assign drop_count_o  = r_drop_count;
   assign err_o         = r_err;

endmodule

// File: tb/tb_bsg_print_stat_tag_tracker.sv
// Bench for bsg_print_stat_tag_tracker: directed table, corner sequences and
// random traffic checked against a queue-based reference model.
module tb_bsg_print_stat_tag_tracker;
   localparam int DW = 32;
   localparam int CW = 8;
   localparam int FE = 4;
   localparam int TE = 16;
   localparam int IW = 4;
   localparam int CYC_MOD = 256;

   logic          clk = 1'b0;
   logic          reset_n_i = 1'b1;
   logic          print_stat_v_i = 1'b0;
   logic [DW-1:0] print_stat_tag_i = '0;
   logic          rec_ready_i = 1'b0;
   logic          rec_v_o;
   logic [1:0]    rec_kind_o;
   logic [IW-1:0] rec_id_o;
   logic [CW-1:0] rec_cycle_o;
   logic [CW-1:0] rec_elapsed_o;
   logic [15:0]   drop_count_o;
   logic          err_o;

   bsg_print_stat_tag_tracker #(
      .data_width_p(DW), .cycle_width_p(CW), .fifo_els_p(FE), .tag_els_p(TE)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n_i),
      .print_stat_v_i(print_stat_v_i), .print_stat_tag_i(print_stat_tag_i),
      .rec_v_o(rec_v_o), .rec_ready_i(rec_ready_i),
      .rec_kind_o(rec_kind_o), .rec_id_o(rec_id_o),
      .rec_cycle_o(rec_cycle_o), .rec_elapsed_o(rec_elapsed_o),
      .drop_count_o(drop_count_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct { int kind; int id; int cyc; int el; } mrec_t;
   mrec_t mq[$];
   int    mcyc;
   bit    mact[TE];
   int    mstart[TE];
   int    merr;
   int    mdrops;
   int    errors = 0;
   int    checks = 0;

   typedef struct {
      bit ev; int kind; int id; bit rdy;
      bit exp_v; int exp_id; int exp_drop; bit exp_err;
   } vec_t;
   vec_t tbl[15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mcyc   = 0;
      merr   = 0;
      mdrops = 0;
      for (int i = 0; i < TE; i++) begin
         mact[i]   = 1'b0;
         mstart[i] = 0;
      end
   endtask

   // One clock edge of the reference: pop from the old queue, then handle the event.
   task automatic model_edge();
      bit    full;
      int    k, id, ts;
      mrec_t r;
      full = (mq.size() == FE);
      ts   = mcyc % CYC_MOD;
      if (mq.size() > 0 && rec_ready_i) void'(mq.pop_front());
      if (print_stat_v_i) begin
         k  = int'(print_stat_tag_i[DW-1:DW-2]);
         id = int'(print_stat_tag_i[IW-1:0]);
         r  = '{k, id, ts, 0};
         if (k == 3) begin
            merr = 1;
         end else begin
            if (k == 1) begin
               mact[id]   = 1'b1;
               mstart[id] = mcyc;
            end else if (k == 2) begin
               if (mact[id]) begin
                  r.el     = (mcyc - mstart[id]) % CYC_MOD;
                  mact[id] = 1'b0;
               end else begin
                  merr = 1;
               end
            end
            if (full) mdrops = (mdrops == 65535) ? 65535 : mdrops + 1;
            else      mq.push_back(r);
         end
      end
      mcyc++;
   endtask

   task automatic check_outputs();
      chk("rec_v", rec_v_o, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("rec_kind", rec_kind_o, mq[0].kind);
         chk("rec_id", rec_id_o, mq[0].id);
         chk("rec_cycle", rec_cycle_o, mq[0].cyc);
         chk("rec_elapsed", rec_elapsed_o, mq[0].el);
      end
      chk("err", err_o, merr);
      chk("drop_count", drop_count_o, mdrops);
   endtask

   task automatic drive(input bit ev, input int kind, input int id, input bit rdy);
      logic [DW-1:0] tag;
      tag = $urandom();
      tag[DW-1 -: 2] = kind[1:0];
      tag[IW-1:0]    = id[IW-1:0];
      print_stat_v_i   = ev;
      print_stat_tag_i = tag;
      rec_ready_i      = rdy;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   // Called at a falling edge; asserts reset between clock edges.
   task automatic do_reset();
      #2;
      reset_n_i      = 1'b0;
      print_stat_v_i = 1'b0;
      #1;
      chk("rst_rec_v", rec_v_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_drop", drop_count_o, 0);
      model_reset();
      repeat (2) @(negedge clk);
      reset_n_i = 1'b1;
   endtask

   initial begin
      tbl[0]  = '{1, 0, 1, 0, 1, 1, 0, 0};
      tbl[1]  = '{1, 0, 2, 0, 1, 1, 0, 0};
      tbl[2]  = '{1, 0, 3, 0, 1, 1, 0, 0};
      tbl[3]  = '{1, 0, 4, 0, 1, 1, 0, 0};
      tbl[4]  = '{1, 0, 5, 0, 1, 1, 1, 0};
      tbl[5]  = '{1, 0, 6, 0, 1, 1, 2, 0};
      tbl[6]  = '{1, 0, 7, 1, 1, 2, 3, 0};
      tbl[7]  = '{1, 0, 8, 1, 1, 3, 3, 0};
      tbl[8]  = '{0, 0, 0, 1, 1, 4, 3, 0};
      tbl[9]  = '{0, 0, 0, 1, 1, 8, 3, 0};
      tbl[10] = '{0, 0, 0, 1, 0, 0, 3, 0};
      tbl[11] = '{1, 0, 9, 1, 1, 9, 3, 0};
      tbl[12] = '{0, 0, 0, 0, 1, 9, 3, 0};
      tbl[13] = '{0, 0, 0, 1, 0, 0, 3, 0};
      tbl[14] = '{1, 3, 2, 1, 0, 0, 3, 1};

      model_reset();
      do_reset();
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].ev, tbl[i].kind, tbl[i].id, tbl[i].rdy);
         chk($sformatf("tbl%0d_v", i), rec_v_o, tbl[i].exp_v);
         if (tbl[i].exp_v) chk($sformatf("tbl%0d_id", i), rec_id_o, tbl[i].exp_id);
         chk($sformatf("tbl%0d_drop", i), drop_count_o, tbl[i].exp_drop);
         chk($sformatf("tbl%0d_err", i), err_o, tbl[i].exp_err);
      end

      // Start id 3 at cycle 10, end at cycle 110.
      do_reset();
      repeat (10) drive(0, 0, 0, 0);
      drive(1, 1, 3, 0);
      repeat (99) drive(0, 0, 0, 0);
      drive(1, 2, 3, 0);
      chk("s38_start_kind", rec_kind_o, 1);
      chk("s38_start_id", rec_id_o, 3);
      chk("s38_start_cycle", rec_cycle_o, 10);
      chk("s38_start_elapsed", rec_elapsed_o, 0);
      drive(0, 0, 0, 1);
      chk("s38_end_kind", rec_kind_o, 2);
      chk("s38_end_id", rec_id_o, 3);
      chk("s38_end_cycle", rec_cycle_o, 110);
      chk("s38_end_elapsed", rec_elapsed_o, 100);
      chk("s38_err", err_o, 0);
      drive(0, 0, 0, 1);
      chk("s38_drained", rec_v_o, 0);

      // Interval spanning the counter wrap: 250 -> 260 mod 256.
      do_reset();
      repeat (250) drive(0, 0, 0, 1);
      drive(1, 1, 7, 1);
      repeat (9) drive(0, 0, 0, 1);
      drive(1, 2, 7, 1);
      chk("s41_v", rec_v_o, 1);
      chk("s41_kind", rec_kind_o, 2);
      chk("s41_id", rec_id_o, 7);
      chk("s41_cycle", rec_cycle_o, 4);
      chk("s41_elapsed", rec_elapsed_o, 10);

      // End without a start.
      drive(1, 2, 5, 1);
      chk("s39_kind", rec_kind_o, 2);
      chk("s39_id", rec_id_o, 5);
      chk("s39_elapsed", rec_elapsed_o, 0);
      chk("s39_err", err_o, 1);
      repeat (5) drive(0, 0, 0, 1);
      chk("s39_err_sticky", err_o, 1);

      // Reserved kind, then reset with records queued.
      do_reset();
      drive(1, 3, 0, 0);
      chk("s42_rsvd_v", rec_v_o, 0);
      chk("s42_rsvd_err", err_o, 1);
      drive(1, 0, 1, 0);
      drive(1, 0, 2, 0);
      drive(1, 0, 3, 0);
      chk("s42_queued_v", rec_v_o, 1);
      do_reset();
      repeat (4) drive(0, 0, 0, 1);
      chk("s42_after_rst_v", rec_v_o, 0);

      // Random traffic: a congested phase, then a mostly-ready phase.
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         bit ev;
         bit rdy;
         int r;
         int k;
         int id;
         ev  = ($urandom_range(0, 1) == 1);
         r   = $urandom_range(0, 15);
         k   = (r < 5) ? 0 : (r < 10) ? 1 : (r < 15) ? 2 : 3;
         id  = (c % 3 == 0) ? $urandom_range(0, TE - 1) : $urandom_range(0, 3);
         rdy = (c < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         if (c == 1500) do_reset();
         drive(ev, k, id, rdy);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
